// File: rtl/glb_read.sv
// glb_read: receiving end of the GLB write stream.
// After a flush pulse and a short settling gap the block accepts 17-bit words
// over valid/ready into a local capture buffer. It stops after TX_SIZE words
// or on the done token (flag bit set, payload 16'h0100) and raises done.
// A registered side port reads the buffer back at any time.
// Optional build macro GLB_READ_THROTTLE_EN gates ready with an 8-bit LFSR
// to model downstream backpressure; without it the sink accepts every cycle.
module glb_read #(
    parameter int TX_SIZE = 32,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [16:0]       data,
    input  logic              valid,
    output logic              ready,
    output logic              done,
    output logic [ADDR_W:0]   num_rx,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [16:0]       rd_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_WAIT  = 3'd2,
        S_RECV  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(TX_SIZE - 1);
    localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W+1)'(TX_SIZE);
    localparam logic [16:0]     TOKEN    = 17'h10100;

    state_t            state_q, state_d;
    logic [1:0]        gap_q, gap_d;
    logic [ADDR_W:0]   num_rx_q, num_rx_d;
    logic [16:0]       rd_data_q;
    logic [16:0]       mem [DEPTH];
    logic              gate;
    logic              xfer;

`ifdef GLB_READ_THROTTLE_EN
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    logic [7:0] lfsr_q, lfsr_d;

    // Throttle LFSR: reseeded on flush, steps once per cycle spent receiving
    always_comb begin
        lfsr_d = lfsr_q;
        if (flush) begin
            lfsr_d = LFSR_SEED;
        end else if (state_q == S_RECV) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // Throttle LFSR register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign gate = lfsr_q[0];
`else
    assign gate = 1'b1;
`endif

    // flush masks ready combinationally so a flush cycle can never complete a transfer
    assign ready   = (state_q == S_RECV) && !flush && gate;
    assign xfer    = valid && ready;
    assign done    = (state_q == S_DONE);
    assign num_rx  = num_rx_q;
    assign rd_data = rd_data_q;

    // Next-state logic: flush overrides everything, otherwise walk the stream phases
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        num_rx_d = num_rx_q;
        if (flush) begin
            state_d  = S_FLUSH;
            gap_d    = 2'd0;
            num_rx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_FLUSH: begin
                    state_d = S_WAIT;
                    gap_d   = 2'd0;
                end
                S_WAIT: begin
                    // three settling cycles before the sink opens
                    if (gap_q == 2'd2) begin
                        state_d = S_RECV;
                    end else begin
                        gap_d = gap_q + 2'd1;
                    end
                end
                S_RECV: begin
                    if (xfer) begin
                        if (num_rx_q != MAX_CNT) begin
                            num_rx_d = num_rx_q + 1'b1;
                        end
                        // the final word (count limit or token) is still stored and counted
                        if ((num_rx_q == LAST_IDX) || (data == TOKEN)) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gap_q    <= 2'd0;
            num_rx_q <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            num_rx_q <= num_rx_d;
        end
    end

    // Capture buffer write; contents survive reset and flush
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[num_rx_q[ADDR_W-1:0]] <= data;
        end
    end

    // Registered readback; a same-cycle write to rd_addr returns the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_glb_read.sv
// tb_glb_read: randomized self-checking bench for glb_read.
// A behavioural stream model (expected count, done flag, buffer image and,
// with GLB_READ_THROTTLE_EN, the backpressure LFSR) predicts every output.
module tb_glb_read;

    localparam int TX    = 32;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam logic [16:0] TOKEN = 17'h10100;

`ifdef GLB_READ_THROTTLE_EN
    localparam bit THR = 1'b1;
`else
    localparam bit THR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [16:0]   data;
    logic          valid;
    logic          ready;
    logic          done;
    logic [AW:0]   num_rx;
    logic [AW-1:0] rd_addr;
    logic [16:0]   rd_data;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    logic [16:0] mbuf [DEPTH];
    int          mcnt;
    bit          mrecv;
    bit          mdone;
    logic [7:0]  mlfsr;
    logic [16:0] txq [$];

    glb_read #(.TX_SIZE(TX), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .done    (done),
        .num_rx  (num_rx),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic exp_ready();
        return mrecv && (THR ? mlfsr[0] : 1'b1);
    endfunction

    // advance the model by one clock with the given producer inputs
    task automatic model_step(input logic v, input logic [16:0] d);
        logic r;
        bit   fin;
        r   = exp_ready();
        fin = 1'b0;
        if (v && r) begin
            mbuf[mcnt] = d;
            mcnt++;
            if (mcnt == TX || d == TOKEN) fin = 1'b1;
        end
        if (mrecv) mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
        if (fin) begin
            mrecv = 1'b0;
            mdone = 1'b1;
        end
    endtask

    // flush pulse then settling gap; ends on the negedge where ready first rises
    task automatic start_stream();
        flush = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready_immediate got=%b exp=0", ready);
        end
        mrecv = 1'b0; mdone = 1'b0; mcnt = 0; mlfsr = 8'hA5;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (num_rx !== '0 || done !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_state num_rx=%0d done=%b ready=%b exp 0/0/0", num_rx, done, ready);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) mrecv = 1'b1;
            checks++;
            if (ready !== exp_ready()) begin
                failures++;
                $display("FAIL gap_ready k=%0d got=%b exp=%b", k, ready, exp_ready());
            end
        end
    endtask

    // drive txq; mode 0 valid always, 1 toggling, 2 random; stops after limit transfers
    task automatic run_stream(input int mode, input int limit, input int budget);
        int          xf;
        int          cyc;
        bit          ph;
        logic        v;
        logic        r;
        logic [16:0] d;
        xf = 0; cyc = 0; ph = 1'b1;
        forever begin
            r = exp_ready();
            checks++;
            if (ready !== r) begin
                failures++;
                $display("FAIL stream_ready cyc=%0d got=%b exp=%b", cyc, ready, r);
            end
            checks++;
            if (num_rx !== (AW+1)'(mcnt)) begin
                failures++;
                $display("FAIL stream_num_rx cyc=%0d got=%0d exp=%0d", cyc, num_rx, mcnt);
            end
            checks++;
            if (done !== mdone) begin
                failures++;
                $display("FAIL stream_done cyc=%0d got=%b exp=%b", cyc, done, mdone);
            end
            if (txq.size() == 0 || mdone || xf == limit) break;
            if (cyc == budget) begin
                checks++;
                failures++;
                $display("FAIL stream_timeout cyc=%0d transfers=%0d exp=%0d", cyc, xf, limit);
                break;
            end
            v  = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
            ph = ~ph;
            d  = txq[0];
            valid = v;
            data  = d;
            if (v && r) begin
                void'(txq.pop_front());
                xf++;
            end
            model_step(v, d);
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_read(input int addr, output logic [16:0] got);
        rd_addr = AW'(addr);
        @(negedge clk);
        got = rd_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; data = '0; rd_addr = '0;
        mrecv = 1'b0; mdone = 1'b0; mcnt = 0; mlfsr = 8'hA5;
        repeat (2) @(negedge clk);
        checks++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl ready=%b done=%b exp 0/0", ready, done);
        end
        checks++;
        if (num_rx !== '0) begin
            failures++;
            $display("FAIL reset_num_rx got=%0d exp=0", num_rx);
        end
        checks++;
        if (rd_data !== 17'h0) begin
            failures++;
            $display("FAIL reset_rd_data got=%h exp=0", rd_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_stream();
        logic [16:0] got;
        txq.delete();
        for (int i = 0; i < TX; i++) txq.push_back(17'(i));
        start_stream();
        run_stream(0, 1000, 400);
        checks++;
        if (num_rx !== 11'd32 || done !== 1'b1) begin
            failures++;
            $display("FAIL full_end num_rx=%0d done=%b exp 32/1", num_rx, done);
        end
        // producer keeps valid high after completion: nothing more is taken
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            model_step(1'b1, data);
            checks++;
            if (ready !== 1'b0 || num_rx !== 11'd32 || done !== 1'b1) begin
                failures++;
                $display("FAIL full_hold ready=%b num_rx=%0d done=%b exp 0/32/1", ready, num_rx, done);
            end
        end
        valid = 1'b0;
        do_read(5, got);
        checks++;
        if (got !== 17'h00005) begin
            failures++;
            $display("FAIL full_read5 got=%h exp=00005", got);
        end
        for (int i = 0; i < 4; i++) begin
            int a;
            a = $urandom_range(0, TX - 1);
            do_read(a, got);
            checks++;
            if (got !== mbuf[a]) begin
                failures++;
                $display("FAIL full_read addr=%0d got=%h exp=%h", a, got, mbuf[a]);
            end
        end
    endtask

    task automatic test_token();
        logic [16:0] got;
        txq.delete();
        txq.push_back(17'h00010); txq.push_back(17'h00011); txq.push_back(TOKEN);
        txq.push_back(17'h00012); txq.push_back(17'h00013);
        start_stream();
        run_stream(0, 1000, 400);
        txq.delete();
        checks++;
        if (num_rx !== 11'd3 || done !== 1'b1) begin
            failures++;
            $display("FAIL token_end num_rx=%0d done=%b exp 3/1", num_rx, done);
        end
        data = 17'h00012; valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            model_step(1'b1, data);
            checks++;
            if (ready !== 1'b0 || num_rx !== 11'd3) begin
                failures++;
                $display("FAIL token_hold ready=%b num_rx=%0d exp 0/3", ready, num_rx);
            end
        end
        valid = 1'b0;
        do_read(2, got);
        checks++;
        if (got !== 17'h10100) begin
            failures++;
            $display("FAIL token_read2 got=%h exp=10100", got);
        end
        do_read(3, got);
        checks++;
        if (got !== 17'h00003) begin
            failures++;
            $display("FAIL token_read3_untouched got=%h exp=00003", got);
        end
    endtask

    task automatic test_toggle();
        logic [16:0] words [8];
        logic [16:0] got;
        txq.delete();
        for (int i = 0; i < 8; i++) begin
            words[i] = 17'($urandom & 32'h0FFFF);
            txq.push_back(words[i]);
        end
        start_stream();
        run_stream(1, 1000, 400);
        checks++;
        if (num_rx !== 11'd8 || done !== 1'b0) begin
            failures++;
            $display("FAIL toggle_end num_rx=%0d done=%b exp 8/0", num_rx, done);
        end
        valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_read(i, got);
            checks++;
            if (got !== words[i]) begin
                failures++;
                $display("FAIL toggle_read addr=%0d got=%h exp=%h", i, got, words[i]);
            end
        end
    endtask

    task automatic test_flush_mid();
        logic [16:0] w9;
        logic [16:0] got;
        txq.delete();
        for (int i = 0; i < 20; i++) txq.push_back(17'($urandom & 32'h0FFFF));
        w9 = txq[9];
        start_stream();
        run_stream(0, 10, 400);
        // a word is offered in the flush cycle; flush must win
        data = 17'h1BEEF; valid = 1'b1;
        start_stream();
        txq.delete();
        for (int i = 0; i < 4; i++) txq.push_back(17'h000AA + 17'(i));
        run_stream(0, 1000, 400);
        checks++;
        if (num_rx !== 11'd4 || done !== 1'b0) begin
            failures++;
            $display("FAIL flush_end num_rx=%0d done=%b exp 4/0", num_rx, done);
        end
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_read(i, got);
            checks++;
            if (got !== 17'h000AA + 17'(i)) begin
                failures++;
                $display("FAIL flush_read addr=%0d got=%h exp=%h", i, got, 17'h000AA + 17'(i));
            end
        end
        do_read(9, got);
        checks++;
        if (got !== w9) begin
            failures++;
            $display("FAIL flush_read9_old got=%h exp=%h", got, w9);
        end
        do_read(10, got);
        checks++;
        if (got !== 17'd10) begin
            failures++;
            $display("FAIL flush_no_write addr=10 got=%h exp=%h", got, 17'd10);
        end
    endtask

    task automatic test_async_reset();
        txq.delete();
        for (int i = 0; i < 20; i++) txq.push_back(17'($urandom & 32'h0FFFF));
        start_stream();
        run_stream(0, 5, 400);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || done !== 1'b0 || num_rx !== '0) begin
            failures++;
            $display("FAIL async_reset ready=%b done=%b num_rx=%0d exp 0/0/0", ready, done, num_rx);
        end
        mrecv = 1'b0; mdone = 1'b0; mcnt = 0; mlfsr = 8'hA5;
        #1 rst_n = 1'b1;
        valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || num_rx !== '0) begin
                failures++;
                $display("FAIL post_reset_idle ready=%b num_rx=%0d exp 0/0", ready, num_rx);
            end
        end
        txq.delete();
        for (int i = 0; i < 3; i++) txq.push_back(17'h00300 + 17'(i));
        start_stream();
        run_stream(0, 1000, 400);
        valid = 1'b0;
        checks++;
        if (num_rx !== 11'd3) begin
            failures++;
            $display("FAIL post_reset_stream num_rx=%0d exp=3", num_rx);
        end
    endtask

    task automatic test_random();
        logic [16:0] got;
        for (int it = 0; it < 4; it++) begin
            int n, exp_n;
            bit exp_d;
            logic [16:0] words [$];
            n = $urandom_range(5, 40);
            words.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 11) == 0) words.push_back(TOKEN);
                else words.push_back(17'($urandom & 32'h1FFFF));
            end
            // expected length straight from the stop rules
            exp_n = n; exp_d = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (words[i] == TOKEN || i + 1 == TX) begin
                    exp_n = i + 1; exp_d = 1'b1;
                    break;
                end
            end
            txq = words;
            start_stream();
            run_stream(2, 1000, 2000);
            txq.delete();
            valid = 1'b0;
            checks++;
            if (num_rx !== (AW+1)'(exp_n) || done !== exp_d) begin
                failures++;
                $display("FAIL random_end it=%0d num_rx=%0d done=%b exp %0d/%b", it, num_rx, done, exp_n, exp_d);
            end
            for (int i = 0; i < exp_n; i++) begin
                do_read(i, got);
                checks++;
                if (got !== words[i]) begin
                    failures++;
                    $display("FAIL random_read it=%0d addr=%0d got=%h exp=%h", it, i, got, words[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_token();
        test_toggle();
        test_flush_mid();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/glb_read.md
Name: glb_read

Overview:
- Synthesizable stream sink: the receiving end of the GLB write stream.
- Accepts 17-bit words over valid/ready after a flush pulse and stores them in a local buffer.
- Stops after TX_SIZE words or an end-of-stream token, then raises done.
- Buffer contents can be read back through a side port, so benches and GLB models can compare captured output against the gold file.

Parameters:
- TX_SIZE, 32: maximum words accepted per stream (1..DEPTH).
- DEPTH, 1024: capture buffer entries.
- ADDR_W, 10: buffer address width, equal to log2(DEPTH).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  stream start/restart; active high
- data  input  17  stream word; bit 16 = token flag, bits 15:0 = payload
- valid  input  1  producer has a word on data
- ready  output  1  sink accepts data this cycle
- done  output  1  stream complete; held until next flush or reset
- num_rx  output  ADDR_W+1  count of words accepted in current stream
- rd_addr  input  ADDR_W  readback address
- rd_data  output  17  buffer[rd_addr]; registered, 1-cycle latency

Behaviour:
- Reset (rst_n low, async): state=IDLE; ready=0, done=0, num_rx=0, rd_data=0, throttle LFSR=seed. Buffer contents are not reset.
- State machine:
  - IDLE: flush=1 -> FLUSH.
  - FLUSH: while flush=1, num_rx=0 and done=0. flush=0 -> WAIT, gap counter=0.
  - WAIT: gap counter counts 3 cycles, then -> RECV.
  - RECV: ready=1 (or gated, see Optional Feature).
  - DONE: ready=0, done=1.
- Transfer = valid && ready sampled at posedge clk: buffer[num_rx] <= data, num_rx <= num_rx+1.
- End of stream, RECV -> DONE on the edge of the transfer where either:
  - num_rx+1 == TX_SIZE, or
  - data[16]==1 && data[15:0]==16'h0100 (done token). The token word is stored and counted.
- ready is combinational from registered state: it drops in the cycle after the final transfer. Never more than TX_SIZE words accepted.
- valid while not in RECV: ignored; nothing stored, num_rx unchanged.
- ready does not depend on valid. The producer may hold valid indefinitely; data may change only after a transfer.
- flush rising in any state (including mid-RECV or DONE): -> FLUSH, clear num_rx/done, ready=0 immediately. Buffer untouched.
- flush asserted the same cycle as a would-be transfer: flush wins, no write.
- num_rx saturates at TX_SIZE. TX_SIZE <= DEPTH, so buffer overflow is impossible.
- Readback: rd_data <= buffer[rd_addr] every cycle, any state. Read-during-write to the same address returns the old data.

Optional Feature:
- Macro: GLB_READ_THROTTLE_EN.
- Defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 at reset and on flush) advances every cycle in RECV; ready = (state==RECV) && lfsr[0]. Models downstream backpressure.
- Undefined: no LFSR; ready = (state==RECV). Accept-every-cycle.

Test Plan:
- Reset, flush 1-cycle pulse, producer valid=1 with data=i for i=0..31, TX_SIZE=32 -> ready rises 4 cycles after flush falls; 32 transfers in 32 consecutive cycles; done=1, num_rx=32; readback addr 5 -> 17'h00005 one cycle later.
- Stream 0x10,0x11, then token 17'h10100 with TX_SIZE=32 -> num_rx=3, done=1 on the edge after the token; buffer[2]=17'h10100; ready=0 afterwards.
- Producer valid toggles 1,0,1,0 for 8 words -> exactly 8 writes at the valid-high cycles; buffer holds words in order, no duplicates.
- flush reasserted after 10 transfers -> ready=0 and num_rx=0 in the same cycle; new stream of 4 words 0xAA..0xAD overwrites addrs 0..3; addr 9 still holds the old value.
- rst_n pulsed low mid-RECV (asynchronous, between edges) -> ready, done, num_rx go 0 without waiting for a clock edge; no transfer until the next flush sequence.
- With GLB_READ_THROTTLE_EN, 32 words -> ready matches the LFSR bit-0 sequence from seed 8'hA5; all 32 words captured in order; done=1.
